// File: rtl/mod_counter_n.sv
// mod_counter_n: parametrised synchronous modulo-N up/down counter with
// parallel load, wrap-or-saturate mode and a zero-latency cascade output (tc).
// Optional build macro MOD_COUNTER_STICKY_OVF_EN adds a sticky overflow flag
// (ovf) with a synchronous clear input (ovf_clr).
module mod_counter_n #(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 7,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef MOD_COUNTER_STICKY_OVF_EN
  input  logic             ovf_clr,
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // A modulus outside 2..2**WIDTH cannot be represented; stop elaboration.
  if (MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_modulus
    $error("mod_counter_n: MODULUS %0d outside 2..2**WIDTH (WIDTH=%0d)", MODULUS, WIDTH);
  end

  // MODULUS may equal 2**WIDTH, so range arithmetic is carried at WIDTH+1 bits.
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);
  localparam bit               SAT     = (SATURATE != 0);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   inc, dec, lv_ext;
  logic             at_top, at_bottom, at_term;
  logic [WIDTH-1:0] load_clamped;

  // Terminal detection and the load clamp; the borrow bit of dec flags q==0.
  always_comb begin
    inc          = {1'b0, q_q} + 1'b1;
    dec          = {1'b0, q_q} - 1'b1;
    lv_ext       = {1'b0, load_val};
    at_top       = (inc == MOD_W);
    at_bottom    = dec[WIDTH];
    at_term      = up_dn ? at_top : at_bottom;
    load_clamped = (lv_ext >= MOD_W) ? TOP_VAL : load_val;
    tc           = en & ~load & ~reset & at_term;
  end

  // Next count: load beats enable; at a range end either wrap or hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_clamped;
    end else if (en) begin
      if (up_dn) begin
        if (at_top) q_d = SAT ? q_q : '0;
        else        q_d = inc[WIDTH-1:0];
      end else begin
        if (at_bottom) q_d = SAT ? q_q : TOP_VAL;
        else           q_d = dec[WIDTH-1:0];
      end
    end
    // tc already excludes load and reset cycles, so it is the wrap event.
    wrap_d = tc;
  end

  // Count and wrap registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef MOD_COUNTER_STICKY_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: a wrap event sets it and wins over a same-edge clear.
  always_comb begin
    ovf_d = ovf_q;
    if (tc)           ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Overflow register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: doc/mod_counter_n.md
Name: mod_counter_n

Overview:
- Parametrised synchronous modulo-N up/down counter.
- Successor to the fixed 3-bit enable-driven T-flip-flop counter.
- Adds configurable width and modulus, direction control, parallel load, a wrap-or-saturate mode, and a cascade output.
- Used as the general counting primitive in timing and sequencing logic; multiple instances chain through tc/en.

Parameters:
WIDTH, 3, counter register width in bits.
MODULUS, 7, count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH; elaboration-time error otherwise.
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clock; no asynchronous paths
en  input  1  count enable (T-equivalent); step taken only when high
up_dn  input  1  1 = count up, 0 = count down; sampled with en
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value loaded when load is high
q  output  WIDTH  current count, registered
tc  output  1  terminal-count cascade, combinational; feeds en of next stage
wrap  output  1  registered one-cycle pulse after a wrap or saturation event

Behaviour:
- Reset: on rising clk with reset=1, q=0 and wrap=0. Reset overrides load and en. Reset mid-count takes effect at that edge, with no partial step.
- Priority per edge: reset > load > en. With en=0 and load=0, q holds and wrap=0.
- Load behaviour:
  - load=1 sets q=load_val. If load_val >= MODULUS, q=MODULUS-1 (clamp).
  - A load cycle never asserts wrap on the next cycle, even if en=1.
- Up step (en=1, up_dn=1):
  - q<MODULUS-1: q+1.
  - q==MODULUS-1 with SATURATE=0: q=0.
  - q==MODULUS-1 with SATURATE=1: q holds.
- Down step (en=1, up_dn=0):
  - q>0: q-1.
  - q==0 with SATURATE=0: q=MODULUS-1.
  - q==0 with SATURATE=1: q holds.
- Terminal value: MODULUS-1 when counting up, 0 when counting down.
- tc = en & ~load & ~reset & (q at terminal value for the current up_dn). Zero latency, for ripple-free cascading of stages.
- wrap is registered and equals the tc value sampled at the previous edge. It is a one-cycle pulse per event in both modes. In saturate mode, it pulses on every enabled cycle spent at the terminal value.
- Arithmetic:
  - Next-state computed at WIDTH+1 bits; no out-of-range q value is ever reachable.
  - MODULUS=2**WIDTH gives natural binary wrap. Default 3/7 gives range 0..6.
- Direction change: may occur on any cycle. The step uses the up_dn value sampled at that edge; no dead cycle.
- Out-of-range q cannot occur after reset. A non-reset power-up value is undefined until the first reset.

Optional Feature:
- Macro: MOD_COUNTER_STICKY_OVF_EN.
- When defined:
  - Adds output ovf (1 bit, registered) and input ovf_clr (1 bit).
  - ovf sets on any edge where wrap would be set to 1, and stays high until ovf_clr=1 or reset.
  - If set and clear occur on the same edge, set wins.
  - Reset value of ovf is 0.
- When undefined: ovf and ovf_clr ports are absent. Logic and behaviour are otherwise identical.

Test Plan:
- Defaults, reset 2 cycles, then en=1 up_dn=1 for 9 cycles -> q = 1,2,3,4,5,6,0,1,2; tc high only while q=6; wrap high the cycle q shows 0.
- WIDTH=4, MODULUS=10, SATURATE=0, load load_val=2, then en=1 up_dn=0 for 4 cycles -> q = 2,1,0,9,8; tc high at q=0; one wrap pulse.
- SATURATE=1 defaults, count up to 6 and keep en=1 for 3 more cycles -> q stays 6; wrap pulses each enabled cycle at 6; down step then gives q=5.
- load_val=7 with MODULUS=7 -> q=6 (clamped). load=1 and en=1 together at q=6 -> q=load value, tc=0, no wrap.
- Reset asserted mid-count at q=4 with load=1 and en=1 -> q=0 next edge, wrap=0, tc=0 during reset.
- Two instances cascaded (stage1 en = stage0 tc), MODULUS=10 each -> 0..99 sequence; stage1 increments exactly once per 10 stage0 enables. With MOD_COUNTER_STICKY_OVF_EN, stage1 ovf sets at 99->0 and clears on ovf_clr.
